// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: host/ALU-facing bus of the micro-program sequencer
interface alu_sequencer_if #(
   parameter int AW     = 3,
   parameter int DATA_W = 7
);
   logic              prog_we;
   logic [AW-1:0]     prog_addr;
   logic [DATA_W+2:0] prog_data;
   logic              start;
   logic              abort;
   logic              alu_carry;
   logic [2:0]        alu_opcode;
   logic [DATA_W-1:0] alu_operand;
   logic              busy;
   logic              done;
   logic              error;
   modport master (
      output prog_we, prog_addr, prog_data, start, abort, alu_carry,
      input  alu_opcode, alu_operand, busy, done, error
   );
   modport slave (
      input  prog_we, prog_addr, prog_data, start, abort, alu_carry,
      output alu_opcode, alu_operand, busy, done, error
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps a small program, issuing one ALU opcode/operand per instruction, branching on carry
module alu_sequencer #(
   parameter int DEPTH     = 8,
   parameter int DATA_W    = 7,
   parameter int MAX_STEPS = 255
) (
   input logic            clk,
   input logic            rst,
   alu_sequencer_if.slave bus
);
   localparam int         AW       = $clog2(DEPTH);
   localparam logic [2:0] OP_HALT  = 3'b110;
   localparam logic [2:0] OP_JC    = 3'b111;
   localparam logic [7:0] STEP_MAX = 8'(MAX_STEPS);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
   state_t            state, nxt, exec_nxt;
   logic [DATA_W+2:0] mem [DEPTH];
   logic [DATA_W+2:0] ir;
   logic [AW-1:0]     pc;
   logic [7:0]        steps;
   logic              error;
   logic [2:0]        op;
   logic [DATA_W-1:0] imm;
   logic              jump, last, issue;
   always_comb begin
      op       = ir[DATA_W+2:DATA_W];
      imm      = ir[DATA_W-1:0];
      jump     = op == OP_JC && bus.alu_carry;
      last     = steps + 8'd1 == STEP_MAX;
      issue    = state == EXEC && op != 3'b000 && !op[2];
      // budget exhaustion wins over HALT/next-pc; falling off the last entry ends the run
      exec_nxt = (last || op == OP_HALT || (!jump && pc == AW'(DEPTH - 1))) ? DONE : FETCH;
      nxt      = state == IDLE  ? (bus.start ? FETCH : IDLE) :
                 state == FETCH ? EXEC :
                 state == EXEC  ? exec_nxt : IDLE;
      if (bus.abort && state != IDLE) nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= '0;
         steps <= '0;
         ir    <= '0;
         error <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            pc    <= '0;
            steps <= '0;
            error <= 1'b0;
         end
         if (state == FETCH) ir <= mem[pc];
         if (state == EXEC) begin
            steps <= steps + 8'd1;
            if (last) error <= 1'b1;
            if (exec_nxt == FETCH) pc <= jump ? imm[AW-1:0] : pc + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && state == IDLE && bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
   end
   assign bus.alu_opcode  = issue ? op : 3'b000;
   assign bus.alu_operand = issue ? imm : '0;
   assign bus.busy        = state == FETCH || state == EXEC;
   assign bus.done        = state == DONE && !bus.abort;
   assign bus.error       = error;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed programs with a scoreboard of expected ALU issues and done pulses
module tb_alu_sequencer;
   localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3, HALT = 3'd6, JC = 3'd7;
   typedef struct {
      bit         is_done;
      logic [2:0] op;
      logic [6:0] opnd;
      bit         err;
      int         cyc;
   } ev_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   run_t0 = 0;
   ev_t  q[$];
   logic [6:0] acc = '0;
   logic       carry = 1'b0;
   logic       force_c = 1'b0;
   alu_sequencer_if #(.AW(3), .DATA_W(7)) bus ();
   alu_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // behavioural ALU: LOAD clears carry, ADD carries out, SUB sets carry on borrow
   always @(posedge clk) begin
      logic [7:0] r;
      if (rst) begin
         acc   <= '0;
         carry <= 1'b0;
      end else if (bus.alu_opcode == LOAD) begin
         acc   <= bus.alu_operand;
         carry <= 1'b0;
      end else if (bus.alu_opcode == ADD) begin
         r = {1'b0, acc} + {1'b0, bus.alu_operand};
         acc   <= r[6:0];
         carry <= r[7];
      end else if (bus.alu_opcode == SUB) begin
         r = {1'b0, acc} - {1'b0, bus.alu_operand};
         acc   <= r[6:0];
         carry <= r[7];
      end
   end
   assign bus.alu_carry = carry | force_c;
   always @(negedge clk) begin
      ev_t e;
      int  rel;
      if (bus.alu_opcode != 3'd0 || bus.done) begin
         vectors++;
         rel = cyc - run_t0 + 1;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected event: op=%0d opnd=%0d done=%0b cycle=%0d, required none",
                     bus.alu_opcode, bus.alu_operand, bus.done, rel);
         end else begin
            e = q.pop_front();
            if (e.is_done != bus.done
                || (!e.is_done && (e.op != bus.alu_opcode || e.opnd != bus.alu_operand))
                || (e.is_done && (e.err != bus.error || bus.busy || bus.alu_operand != 0))
                || (e.cyc >= 0 && e.cyc != rel)) begin
               miscompares++;
               $display("FAIL event: got done=%0b op=%0d opnd=%0d err=%0b cycle=%0d, required done=%0b op=%0d opnd=%0d err=%0b cycle=%0d",
                        bus.done, bus.alu_opcode, bus.alu_operand, bus.error, rel,
                        e.is_done, e.op, e.opnd, e.err, e.cyc);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask
   task automatic wr(input int a, input logic [2:0] op, input logic [6:0] imm);
      bus.prog_addr = 3'(a);
      bus.prog_data = {op, imm};
      bus.prog_we   = 1'b1;
      tick();
      bus.prog_we   = 1'b0;
   endtask
   task automatic go();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      run_t0    = cyc;
   endtask
   task automatic exp_op(input logic [2:0] op, input logic [6:0] imm, input int c);
      q.push_back('{is_done: 1'b0, op: op, opnd: imm, err: 1'b0, cyc: c});
   endtask
   task automatic exp_done(input bit err, input int c);
      q.push_back('{is_done: 1'b1, op: 3'd0, opnd: 7'd0, err: err, cyc: c});
   endtask
   task automatic wait_done(input string name, input int limit);
      int n = 0;
      @(negedge clk);
      while (!bus.done && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({name, " done seen"}, int'(bus.done), 1);
      tick();
      check({name, " pending events"}, q.size(), 0);
   endtask
   task automatic idle_check(input string name, input int n);
      repeat (n) tick();
      check({name, " pending events"}, q.size(), 0);
      check({name, " busy"}, int'(bus.busy), 0);
   endtask
   task automatic load_t1();
      wr(0, LOAD, 7'd5);
      wr(1, ADD, 7'd3);
      wr(2, HALT, 7'd0);
   endtask
   initial begin
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
      bus.start = 1'b0; bus.abort = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset error", int'(bus.error), 0);
      check("reset opcode", int'(bus.alu_opcode), 0);
      check("reset operand", int'(bus.alu_operand), 0);
      rst = 1'b0;
      tick();
      load_t1();
      exp_op(LOAD, 7'd5, 2); exp_op(ADD, 7'd3, 4); exp_done(1'b0, 7);
      go();
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         check($sformatf("t1 busy c%0d", c), int'(bus.busy), int'(c <= 6));
         tick();
      end
      check("t1 error", int'(bus.error), 0);
      check("t1 pending events", q.size(), 0);
      wr(0, LOAD, 7'd100);
      wr(1, ADD, 7'd10);
      wr(2, JC, 7'd7);
      wr(3, ADD, 7'd20);
      wr(4, JC, 7'd6);
      wr(5, ADD, 7'd1);
      wr(6, SUB, 7'd5);
      wr(7, HALT, 7'd0);
      exp_op(LOAD, 7'd100, 2); exp_op(ADD, 7'd10, 4); exp_op(ADD, 7'd20, 8);
      exp_op(SUB, 7'd5, 12); exp_done(1'b0, 15);
      go();
      wait_done("t2", 100);
      check("t2 acc", int'(acc), 125);
      wr(0, NOP, 7'd0);
      wr(1, JC, 7'd0);
      force_c = 1'b1;
      exp_done(1'b1, 511);
      go();
      wait_done("t3", 2000);
      force_c = 1'b0;
      check("t3 error sticky", int'(bus.error), 1);
      for (int i = 0; i < 8; i++) wr(i, NOP, 7'(i));
      exp_done(1'b0, 17);
      go();
      @(negedge clk);
      check("t4 error cleared by start", int'(bus.error), 0);
      wait_done("t4", 100);
      load_t1();
      exp_op(LOAD, 7'd5, 2); exp_op(ADD, 7'd3, 4); exp_done(1'b0, 7);
      go();
      tick();
      bus.prog_addr = 3'd0; bus.prog_data = {LOAD, 7'd99};
      bus.prog_we = 1'b1; bus.start = 1'b1;
      tick();
      bus.prog_we = 1'b0; bus.start = 1'b0;
      wait_done("t5", 100);
      exp_op(LOAD, 7'd5, 2); exp_op(ADD, 7'd3, 4); exp_done(1'b0, 7);
      go();
      wait_done("t5 readback", 100);
      exp_op(LOAD, 7'd5, 2);
      go();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6 rst busy", int'(bus.busy), 0);
      check("t6 rst opcode", int'(bus.alu_opcode), 0);
      check("t6 rst error", int'(bus.error), 0);
      idle_check("t6 rst", 10);
      go();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      @(negedge clk);
      check("t6 abort fetch busy", int'(bus.busy), 0);
      check("t6 abort fetch opcode", int'(bus.alu_opcode), 0);
      idle_check("t6 abort fetch", 10);
      exp_op(LOAD, 7'd5, 2);
      go();
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      idle_check("t6 abort exec", 10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
